// File: rtl/osd_mam_wb_arb.sv
// Two-master, one-slave Wishbone B3 arbiter: grant is held for the whole bus cycle, with
// round-robin on contention. Optional watchdog lockout: define OSD_MAM_WB_ARB_TIMEOUT_EN.
module osd_mam_wb_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  localparam int unsigned SW        = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SW-1:0]         m0_sel_i,
  input  logic [2:0]            m0_cti_i,
  input  logic [1:0]            m0_bte_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,

  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SW-1:0]         m1_sel_i,
  input  logic [2:0]            m1_cti_i,
  input  logic [1:0]            m1_bte_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,

  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_addr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SW-1:0]         s_sel_o,
  output logic [2:0]            s_cti_o,
  output logic [1:0]            s_bte_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,

  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   own0, own1;
  logic   req0, req1;
  logic   tmo0, tmo1;

  // last == 1 means m1 was served most recently, so m0 wins a tie.
  function automatic state_e arb(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return last ? StOwn0 : StOwn1;
    if (r0)       return StOwn0;
    if (r1)       return StOwn1;
    return StIdle;
  endfunction

  assign own0    = (state_q == StOwn0);
  assign own1    = (state_q == StOwn1);
  assign grant_o = {own1, own0};

`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        lock0_q, lock0_d, lock1_q, lock1_d;
  logic        stall;

  assign stall = (own0 | own1) & s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
  assign tmo0  = own0 & (cnt_q == 16'(TIMEOUT));
  assign tmo1  = own1 & (cnt_q == 16'(TIMEOUT));
  // A timed-out master stays masked until it drops cyc on its own.
  assign req0  = m0_cyc_i & ~lock0_q & ~tmo0;
  assign req1  = m1_cyc_i & ~lock1_q & ~tmo1;

  always_comb begin
    cnt_d   = (stall && !tmo0 && !tmo1) ? cnt_q + 16'd1 : 16'd0;
    lock0_d = (lock0_q | tmo0) & m0_cyc_i;
    lock1_d = (lock1_q | tmo1) & m1_cyc_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 16'd0;
      lock0_q <= 1'b0;
      lock1_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lock0_q <= lock0_d;
      lock1_q <= lock1_d;
    end
  end
`else
  assign tmo0 = 1'b0;
  assign tmo1 = 1'b0;
  assign req0 = m0_cyc_i;
  assign req1 = m1_cyc_i;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      StOwn0: begin
        if (!m0_cyc_i || tmo0) begin
          last_d  = 1'b0;
          state_d = arb(req0, req1, 1'b0);
        end
      end
      StOwn1: begin
        if (!m1_cyc_i || tmo1) begin
          last_d  = 1'b1;
          state_d = arb(req0, req1, 1'b1);
        end
      end
      default: state_d = arb(req0, req1, last_q);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_cti_o  = 3'b000;
    s_bte_o  = 2'b00;
    if (own0) begin
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
      s_we_o   = m0_we_i;
      s_addr_o = m0_addr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_cti_o  = m0_cti_i;
      s_bte_o  = m0_bte_i;
    end else if (own1) begin
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
      s_we_o   = m1_we_i;
      s_addr_o = m1_addr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_cti_o  = m1_cti_i;
      s_bte_o  = m1_bte_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 & s_ack_i;
  assign m1_ack_o = own1 & s_ack_i;
  assign m0_err_o = own0 & (s_err_i | tmo0);
  assign m1_err_o = own1 & (s_err_i | tmo1);

endmodule

// File: tb/tb_osd_mam_wb_arb.sv
// Directed bench for osd_mam_wb_arb; the timeout section runs only with
// OSD_MAM_WB_ARB_TIMEOUT_EN defined.
module tb_osd_mam_wb_arb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
  logic [3:0]    m0_sel, m1_sel, s_sel;
  logic [2:0]    m0_cti, m1_cti, s_cti;
  logic [1:0]    m0_bte, m1_bte, s_bte, grant;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic          s_cyc, s_stb, s_we, s_ack, s_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  osd_mam_wb_arb #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
    .TIMEOUT    (8)
`else
    .TIMEOUT    (255)
`endif
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .m0_cyc_i  (m0_cyc),
    .m0_stb_i  (m0_stb),
    .m0_we_i   (m0_we),
    .m0_addr_i (m0_addr),
    .m0_dat_i  (m0_wdat),
    .m0_sel_i  (m0_sel),
    .m0_cti_i  (m0_cti),
    .m0_bte_i  (m0_bte),
    .m0_dat_o  (m0_rdat),
    .m0_ack_o  (m0_ack),
    .m0_err_o  (m0_err),
    .m1_cyc_i  (m1_cyc),
    .m1_stb_i  (m1_stb),
    .m1_we_i   (m1_we),
    .m1_addr_i (m1_addr),
    .m1_dat_i  (m1_wdat),
    .m1_sel_i  (m1_sel),
    .m1_cti_i  (m1_cti),
    .m1_bte_i  (m1_bte),
    .m1_dat_o  (m1_rdat),
    .m1_ack_o  (m1_ack),
    .m1_err_o  (m1_err),
    .s_cyc_o   (s_cyc),
    .s_stb_o   (s_stb),
    .s_we_o    (s_we),
    .s_addr_o  (s_addr),
    .s_dat_o   (s_wdat),
    .s_sel_o   (s_sel),
    .s_cti_o   (s_cti),
    .s_bte_o   (s_bte),
    .s_dat_i   (s_rdat),
    .s_ack_i   (s_ack),
    .s_err_i   (s_err),
    .grant_o   (grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdat = 32'h0000_00aa; m1_wdat = 32'h0000_00bb;
    m0_sel = 4'hf; m1_sel = 4'h3; m0_cti = 3'b000; m1_cti = 3'b000;
    m0_bte = 2'b00; m1_bte = 2'b01;
    s_rdat = '0; s_ack = 1'b0; s_err = 1'b0;
    tick();
    tick();
    chk("rst_grant", 64'(grant), 64'(2'b00));
    chk("rst_scyc", 64'(s_cyc), 64'd0);
    chk("rst_sstb", 64'(s_stb), 64'd0);
    chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    rst = 1'b0;

    // m1 4-beat incrementing read burst
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b010; m1_addr = 32'h100;
    #1;
    chk("b_latency_scyc", 64'(s_cyc), 64'd0);
    tick();
    chk("b_grant", 64'(grant), 64'(2'b10));
    chk("b_scyc", 64'(s_cyc), 64'd1);
    chk("b_scti", 64'(s_cti), 64'(3'b010));
    chk("b_sbte_sel", 64'({s_bte, s_sel}), 64'({2'b01, 4'h3}));
    s_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_rdat = 32'ha0 + 32'(i);
      m1_addr = 32'h100 + 32'(4 * i);
      if (i == 3) m1_cti = 3'b111;
      #1;
      chk("b_m1ack", 64'(m1_ack), 64'd1);
      chk("b_m0ack", 64'(m0_ack), 64'd0);
      chk("b_m1dat", 64'(m1_rdat), 64'(32'ha0 + 32'(i)));
      chk("b_saddr", 64'(s_addr), 64'(32'h100 + 32'(4 * i)));
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0; m1_cti = 3'b000;
    #1;
    chk("b_grant_hold", 64'(grant), 64'(2'b10));
    chk("b_scyc_drop", 64'(s_cyc), 64'd0);
    tick();
    chk("b_grant_idle", 64'(grant), 64'(2'b00));

    // contention and round-robin
    m0_addr = 32'h200; m1_addr = 32'h300;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("c1_grant", 64'(grant), 64'(2'b01));
    chk("c1_saddr", 64'(s_addr), 64'h200);
    chk("c1_sdat", 64'(s_wdat), 64'haa);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("c2_nogap", 64'(grant), 64'(2'b10));
    chk("c2_saddr", 64'(s_addr), 64'h300);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("c3_idle", 64'(grant), 64'(2'b00));
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("c4_rr_m0", 64'(grant), 64'(2'b01));
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("c5_idle", 64'(grant), 64'(2'b00));
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    chk("c6_rr_m1", 64'(grant), 64'(2'b10));
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("c7_idle", 64'(grant), 64'(2'b00));

    // no preemption while m1 holds cyc (locked cycle)
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_cti = 3'b111;
    tick();
    chk("p_grant", 64'(grant), 64'(2'b10));
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      m1_addr = 32'h400 + 32'(i);
      #1;
      chk("p_hold", 64'({grant, m0_ack}), 64'({2'b10, 1'b0}));
      chk("p_saddr", 64'(s_addr), 64'(32'h400 + 32'(i)));
      tick();
    end
    s_ack = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_cti = 3'b000;
    tick();
    chk("p_m0_after", 64'(grant), 64'(2'b01));

    // slave error during OWN0
    s_err = 1'b1;
    #1;
    chk("e_m0err", 64'(m0_err), 64'd1);
    chk("e_m1err", 64'(m1_err), 64'd0);
    chk("e_grant", 64'(grant), 64'(2'b01));
    tick();
    s_err = 1'b0;
    chk("e_grant_next", 64'(grant), 64'(2'b01));

    // reset mid-burst restores last_owner=1
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("r_pre_grant", 64'(grant), 64'(2'b10));
    rst = 1'b1;
    tick();
    chk("r_grant", 64'(grant), 64'(2'b00));
    chk("r_scyc", 64'(s_cyc), 64'd0);
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("r_last_owner", 64'(grant), 64'(2'b01));

`ifdef OSD_MAM_WB_ARB_TIMEOUT_EN
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_addr = 32'h500;
    tick();
    chk("t_grant", 64'(grant), 64'(2'b01));
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h600;
    for (int i = 0; i < 8; i++) begin
      chk("t_stall_noerr", 64'(m0_err), 64'd0);
      tick();
    end
    chk("t_err_pulse", 64'({m0_err, m1_err}), 64'({1'b1, 1'b0}));
    tick();
    chk("t_m1_granted", 64'(grant), 64'(2'b10));
    chk("t_m0err_once", 64'(m0_err), 64'd0);
    chk("t_saddr", 64'(s_addr), 64'h600);
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("t_m0_ignored", 64'(grant), 64'(2'b00));
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("t_m0_back", 64'(grant), 64'(2'b01));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end
endmodule
